// File: rtl/rfs_uart_pkg.sv
// Shared definitions for the RFS Bluetooth UART receive path.
// Holds the receiver FSM state type, the register word addresses, the STATUS
// and RXDATA bit positions, and the default bit period for 115200 baud at 50 MHz.
package rfs_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam logic [1:0] ADDR_RXDATA = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int RXDATA_VALID_BIT = 8;
    localparam int STATUS_FERR_BIT  = 9;
    localparam int STATUS_OVF_BIT   = 8;
    localparam int CTRL_RXEN_BIT    = 0;

endpackage

// File: rtl/rfs_sync_fifo.sv
// Single-clock FIFO buffering received bytes.
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   push, din      - write request and data; accepted when not full, or when
//                    a pop happens in the same cycle
//   pop, dout      - read request and head-of-queue data (show-ahead)
//   full, empty    - occupancy flags derived from the registered count
//   count          - number of stored entries, 0..DEPTH
module rfs_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign pop_ok_s  = pop & ~empty;
    // A pop frees a slot within the same cycle, so a full FIFO still takes the push.
    assign push_ok_s = push & (~full | pop_ok_s);
    assign dout      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy count; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rfs_uart_rx.sv
// Receive half of the RFS Bluetooth serial link with an Avalon-MM slave front end.
// Deserialises 8N1 frames from rxd, buffers bytes in rfs_sync_fifo and exposes
// them to the HPS.
// Ports:
//   clk, reset          - 50 MHz clock, synchronous active-high reset
//   rxd                 - asynchronous serial input, idles high
//   chipselect, read,   - Avalon-MM slave strobes
//   write, address,
//   writedata
//   readdata            - registered read data, one cycle read latency
//   irq                 - registered, high while the FIFO holds bytes
// Registers: 0 RXDATA {valid, byte} (pops), 1 STATUS {FERR, OVF, count} with
// W1C flags, 2 CTRL {RXEN}, 3 reserved.
module rfs_uart_rx
    import rfs_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       rx_sync_r;
    logic             rx_s;
    logic             rx_q_r;
    rx_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             rx_push_r;
    logic             ferr_set_r;
    logic             ferr_r;
    logic             ovf_r;
    logic             rxen_r;
    logic [31:0]      readdata_r;
    logic             irq_r;

    logic             rd_access_s;
    logic             wr_access_s;
    logic             pop_s;
    logic             ferr_clr_s;
    logic             ovf_clr_s;
    logic             ovf_set_s;
    logic [7:0]       fifo_dout_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CW-1:0]    fifo_count_s;
    logic [31:0]      status_s;
    logic [31:0]      rxdata_s;
    logic             unused_wdata_s;

    assign rx_s           = rx_sync_r[1];
    assign rd_access_s    = chipselect & read;
    assign wr_access_s    = chipselect & write;
    assign pop_s          = rd_access_s & (address == ADDR_RXDATA) & ~fifo_empty_s;
    assign ferr_clr_s     = wr_access_s & (address == ADDR_STATUS) & writedata[STATUS_FERR_BIT];
    assign ovf_clr_s      = wr_access_s & (address == ADDR_STATUS) & writedata[STATUS_OVF_BIT];
    // Only a full FIFO without a same-cycle pop loses the byte.
    assign ovf_set_s      = rx_push_r & fifo_full_s & ~pop_s;
    assign unused_wdata_s = ^{writedata[31:10], writedata[7:1]};
    assign readdata       = readdata_r;
    assign irq            = irq_r;

    rfs_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push_r),
        .pop   (pop_s),
        .din   (shift_r),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Two-flop synchroniser plus previous-sample register for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync_r <= 2'b11;
            rx_q_r    <= 1'b1;
        end else begin
            rx_sync_r <= {rx_sync_r[0], rxd};
            rx_q_r    <= rx_s;
        end
    end

    // Frame deserialiser: start qualification at half bit, data/stop at bit centres.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            rx_push_r  <= 1'b0;
            ferr_set_r <= 1'b0;
        end else begin
            rx_push_r  <= 1'b0;
            ferr_set_r <= 1'b0;
            if (!rxen_r) begin
                state_r <= IDLE;
                cnt_r   <= {CNT_W{1'b0}};
            end else begin
                case (state_r)
                    IDLE: begin
                        // Edge-triggered, so a line held low (break) cannot restart a frame.
                        if (rx_q_r && !rx_s) begin
                            state_r <= START;
                            cnt_r   <= {CNT_W{1'b0}};
                        end
                    end
                    START: begin
                        if (cnt_r == HALF_M1) begin
                            cnt_r     <= {CNT_W{1'b0}};
                            bit_idx_r <= 3'd0;
                            if (!rx_s) begin
                                state_r <= DATA;
                            end else begin
                                state_r <= IDLE;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (cnt_r == FULL_M1) begin
                            cnt_r   <= {CNT_W{1'b0}};
                            shift_r <= {rx_s, shift_r[7:1]};
                            if (bit_idx_r == 3'd7) begin
                                state_r <= STOP;
                            end else begin
                                bit_idx_r <= bit_idx_r + 3'd1;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        if (cnt_r == FULL_M1) begin
                            cnt_r   <= {CNT_W{1'b0}};
                            state_r <= IDLE;
                            if (rx_s) begin
                                rx_push_r <= 1'b1;
                            end else begin
                                ferr_set_r <= 1'b1;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    // Sticky error flags; a set in the same cycle as its clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ferr_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            ferr_r <= ferr_set_r | (ferr_r & ~ferr_clr_s);
            ovf_r  <= ovf_set_s  | (ovf_r  & ~ovf_clr_s);
        end
    end

    // CTRL register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxen_r <= 1'b1;
        end else if (wr_access_s && (address == ADDR_CTRL)) begin
            rxen_r <= writedata[CTRL_RXEN_BIT];
        end else begin
            rxen_r <= rxen_r;
        end
    end

    // Read-data words for RXDATA and STATUS.
    always_comb begin
        status_s                  = 32'h0000_0000;
        status_s[CW-1:0]          = fifo_count_s;
        status_s[STATUS_OVF_BIT]  = ovf_r;
        status_s[STATUS_FERR_BIT] = ferr_r;
        rxdata_s                  = 32'h0000_0000;
        if (!fifo_empty_s) begin
            rxdata_s[7:0]             = fifo_dout_s;
            rxdata_s[RXDATA_VALID_BIT] = 1'b1;
        end else begin
            rxdata_s = 32'h0000_0000;
        end
    end

    // Registered read mux; zero whenever no read is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_r <= 32'h0000_0000;
        end else if (rd_access_s) begin
            case (address)
                ADDR_RXDATA: readdata_r <= rxdata_s;
                ADDR_STATUS: readdata_r <= status_s;
                ADDR_CTRL:   readdata_r <= {31'h0000_0000, rxen_r};
                ADDR_RSVD:   readdata_r <= 32'h0000_0000;
                default:     readdata_r <= 32'h0000_0000;
            endcase
        end else begin
            readdata_r <= 32'h0000_0000;
        end
    end

    // Interrupt follows FIFO non-empty one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= ~fifo_empty_s;
        end
    end

endmodule

// File: tb/tb_rfs_uart_rx.sv
// Directed bench for rfs_uart_rx. A short bit period keeps the run small; the
// glitch pulse is scaled to stay well below half a bit period.
module tb_rfs_uart_rx;

    localparam int CPB    = 16;
    localparam int DEPTH  = 16;
    localparam int GLITCH = CPB / 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rxd = 1'b1;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [1:0]  address = 2'd0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int irq_rise = -1;
    logic [31:0] rd;

    always #10 clk = ~clk;

    rfs_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives the first nbits of an 8N1 frame (start, 8 data LSB first, stop).
    task automatic send_bits(input logic [7:0] b, input logic stop_bit, input int nbits);
        logic [9:0] fr;
        int cyc;
        fr = {stop_bit, b, 1'b0};
        cyc = 0;
        irq_rise = -1;
        for (int i = 0; i < nbits; i++) begin
            for (int k = 0; k < CPB; k++) begin
                @(negedge clk);
                if (irq && irq_rise < 0) irq_rise = cyc;
                if (k == 0) rxd = fr[i];
                cyc++;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_bits(b, stop_bit, 10);
        rxd = 1'b1;
        idle(4);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; writedata = 32'h0;
    endtask

    initial begin
        // Reset state
        idle(3);
        reset = 1'b0;
        idle(2);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        bus_read(2'd1, rd); check("reset_status", rd, 32'h0);
        bus_read(2'd2, rd); check("reset_ctrl", rd, 32'h1);
        bus_read(2'd3, rd); check("addr3_read", rd, 32'h0);
        @(negedge clk);
        check("readdata_idle_zero", readdata, 32'h0);

        // Single byte 0xA5; push lands about 9.5 bit times after the start edge
        send_frame(8'hA5, 1'b1);
        check("irq_rise_window", {31'h0, (irq_rise >= (19 * CPB) / 2) && (irq_rise <= (19 * CPB) / 2 + 7)}, 32'h1);
        bus_read(2'd1, rd); check("a5_status_count1", rd, 32'h1);
        bus_write(2'd0, 32'h0000_00FF);
        bus_read(2'd0, rd); check("a5_rxdata", rd, 32'h1A5);
        check("a5_irq_before_lag", {31'h0, irq}, 32'h1);
        @(negedge clk);
        check("a5_irq_fall", {31'h0, irq}, 32'h0);
        bus_read(2'd1, rd); check("a5_status_after", rd, 32'h0);
        bus_read(2'd0, rd); check("empty_read_zero", rd, 32'h0);

        // Short low glitch is rejected in START
        @(negedge clk); rxd = 1'b0;
        idle(GLITCH);
        rxd = 1'b1;
        idle(2 * CPB);
        bus_read(2'd1, rd); check("glitch_status", rd, 32'h0);
        check("glitch_irq", {31'h0, irq}, 32'h0);

        // Framing error
        send_frame(8'h3C, 1'b0);
        idle(CPB);
        bus_read(2'd1, rd); check("ferr_set", rd, 32'h200);
        bus_write(2'd1, 32'h200);
        bus_read(2'd1, rd); check("ferr_clear", rd, 32'h0);

        // Overflow: 17 bytes, last one lost
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
        bus_read(2'd1, rd); check("ovf_status", rd, 32'h110);
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd0, rd); check($sformatf("ovf_drain_%0d", i), rd, 32'h100 + 32'(i));
        end
        bus_read(2'd0, rd); check("ovf_drain_empty", rd, 32'h0);
        bus_write(2'd1, 32'h100);
        bus_read(2'd1, rd); check("ovf_clear", rd, 32'h0);

        // Full FIFO: pop in the same cycle as the 17th push
        for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1);
        bus_read(2'd1, rd); check("full_status", rd, 32'h010);
        fork
            send_frame(8'h30, 1'b1);
            begin
                bit got;
                got = 1'b0;
                for (int w = 0; w < 12 * CPB && !got; w++) begin
                    @(negedge clk);
                    if (dut.rx_push_r) begin
                        chipselect = 1'b1; read = 1'b1; address = 2'd0;
                        got = 1'b1;
                    end
                end
                check("push_seen", {31'h0, got}, 32'h1);
                @(negedge clk);
                rd = readdata;
                chipselect = 1'b0; read = 1'b0;
            end
        join
        check("same_cycle_pop", rd, 32'h120);
        bus_read(2'd1, rd); check("same_cycle_status", rd, 32'h010);
        for (int i = 1; i <= 16; i++) begin
            bus_read(2'd0, rd); check($sformatf("full_drain_%0d", i), rd, 32'h120 + 32'(i));
        end
        bus_read(2'd1, rd); check("full_drained", rd, 32'h0);

        // Reset in the middle of DATA drops the partial byte
        send_bits(8'h00, 1'b1, 4);
        @(negedge clk); reset = 1'b1; rxd = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(CPB);
        send_frame(8'h55, 1'b1);
        bus_read(2'd0, rd); check("rst_mid_rxdata", rd, 32'h155);
        bus_read(2'd0, rd); check("rst_mid_only_one", rd, 32'h0);

        // Clearing RXEN mid-frame aborts it
        send_bits(8'h00, 1'b1, 5);
        bus_write(2'd2, 32'h0);
        bus_read(2'd2, rd); check("rxen_cleared", rd, 32'h0);
        rxd = 1'b1;
        idle(12 * CPB);
        bus_write(2'd2, 32'h1);
        idle(2 * CPB);
        bus_read(2'd1, rd); check("rxen_abort_status", rd, 32'h0);
        check("rxen_abort_irq", {31'h0, irq}, 32'h0);
        send_frame(8'h81, 1'b1);
        bus_read(2'd0, rd); check("rxen_reenabled", rd, 32'h181);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
